// File: rtl/dmem_responder.sv
// Data-memory responder behind the pipeline's dmem port: accepts one load/store and completes it after LATENCY wait cycles.
// done/rvalid arrive LATENCY+1 cycles after accept. busy is held meanwhile and new requests are ignored; illegal requests pulse err.
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_busy,
  output logic        o_dmem_done,
  output logic        o_dmem_rvalid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    mask;
  } req_t;

  logic [1:0]  rst_sync;
  logic        rst_n;
  state_t      state;
  state_t      state_nxt;
  req_t        req_q;
  logic [3:0]  cnt;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [30:0] word_off;
  logic        req_any;
  logic        req_bad;
  logic        can_accept;
  logic        accept;
  logic        reject;
  logic        last_wait;
  logic        busy;
  logic        done;
  logic        rvalid;
  logic [31:0] mem [DEPTH];

  // Reset asserts immediately but releases two edges after i_rst_n rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Word offset from the base; bit 30 set means the address is below the base.
  assign word_off   = {1'b0, i_dmem_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign req_any    = i_dmem_ren | i_dmem_wen;
  assign req_bad    = (i_dmem_ren & i_dmem_wen)
                    | (|i_dmem_addr[1:0])
                    | word_off[30]
                    | (|word_off[29:AW])
                    | (i_dmem_wen & ~(|i_dmem_mask));
  assign can_accept = (state == IDLE) || (state == RESP);
  assign accept     = can_accept & req_any & ~req_bad;
  assign reject     = can_accept & req_any & req_bad;
  assign last_wait  = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = accept ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    rvalid = 1'b0;
    case (state)
      WAIT: busy = 1'b1;
      RESP: begin
        done   = 1'b1;
        rvalid = ~req_q.wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      cnt     <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      err_q <= reject;
      if (accept) begin
        req_q.wr    <= i_dmem_wen;
        req_q.idx   <= word_off[AW-1:0];
        req_q.wdata <= i_dmem_wdata;
        req_q.mask  <= i_dmem_mask;
        cnt         <= 4'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (last_wait && !req_q.wr) rdata_q <= mem[req_q.idx];
    end
  end

  // Memory contents survive reset; an aborted write never reaches last_wait.
  always_ff @(posedge i_clk) begin
    if (last_wait && req_q.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (req_q.mask[b]) mem[req_q.idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
      end
    end
  end

  assign o_dmem_busy   = busy;
  assign o_dmem_done   = done;
  assign o_dmem_rvalid = rvalid;
  assign o_dmem_rdata  = rdata_q;
  assign o_dmem_err    = err_q;

endmodule
